// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
// The flush port is only present when ROB_FLUSH_EN is defined.
package rob_pkg;

    localparam int ROB_DEPTH     = 64;
    localparam int ROB_IDX_WIDTH = $clog2(ROB_DEPTH);
    localparam int PREG_WIDTH    = 6;
    localparam int AREG_WIDTH    = 5;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  reg_write;
        logic [AREG_WIDTH-1:0] rd;
        logic [PREG_WIDTH-1:0] prd;
        logic [PREG_WIDTH-1:0] old_prd;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around circular-buffer pointer with enable and synchronous clear.
// Wrapping is implicit because the buffer depth is a power of two.
module rob_ptr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates in order, marks completions by tag, retires the oldest done entry.
// Define ROB_FLUSH_EN to add the synchronous `flush` input.
module rob
    import rob_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int IDX_WIDTH = ROB_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ROB_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  alloc_valid,
    input  logic                  alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] alloc_rd,
    input  logic [PREG_WIDTH-1:0] alloc_prd,
    input  logic [PREG_WIDTH-1:0] alloc_old_prd,
    output logic                  alloc_ready,
    output logic [IDX_WIDTH-1:0]  rob_num,
    input  logic                  cmpl0_valid,
    input  logic [IDX_WIDTH-1:0]  cmpl0_idx,
    input  logic                  cmpl1_valid,
    input  logic [IDX_WIDTH-1:0]  cmpl1_idx,
    output logic                  rob_push,
    output logic [PREG_WIDTH-1:0] rob_free_reg,
    output logic                  retire_valid,
    output logic [AREG_WIDTH-1:0] retire_rd,
    output logic [PREG_WIDTH-1:0] retire_prd,
    output logic [IDX_WIDTH:0]    count
);

    logic flush_w;
`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];

    logic [IDX_WIDTH-1:0]  head_q;
    logic [IDX_WIDTH-1:0]  tail_q;
    logic [IDX_WIDTH:0]    count_q;
    logic [IDX_WIDTH:0]    count_d;
    rob_entry_t            head_entry;
    logic                  alloc_fire;
    logic                  retire_fire;

    logic                  retire_valid_q;
    logic                  rob_push_q;
    logic [AREG_WIDTH-1:0] retire_rd_q;
    logic [PREG_WIDTH-1:0] retire_prd_q;
    logic [PREG_WIDTH-1:0] rob_free_reg_q;

    assign head_entry  = entries_q[head_q];
    assign alloc_ready = (count_q != (IDX_WIDTH+1)'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign retire_fire = head_entry.valid && head_entry.done;
    assign rob_num     = tail_q;
    assign count       = count_q;

    rob_ptr #(.W(IDX_WIDTH)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (flush_w),
        .en_i  (retire_fire),
        .ptr_o (head_q)
    );

    rob_ptr #(.W(IDX_WIDTH)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (flush_w),
        .en_i  (alloc_fire),
        .ptr_o (tail_q)
    );

    // Completion, retire and allocation never touch the same live entry, so update order is immaterial.
    always_comb begin
        // NOTE: blocking assignments here build next-state incrementally; registers below use non-blocking only.
        entries_d = entries_q;
        if (cmpl0_valid && entries_q[cmpl0_idx].valid) begin
            entries_d[cmpl0_idx].done = 1'b1;
        end
        if (cmpl1_valid && entries_q[cmpl1_idx].valid) begin
            entries_d[cmpl1_idx].done = 1'b1;
        end
        if (retire_fire) begin
            entries_d[head_q].valid = 1'b0;
        end
        if (alloc_fire) begin
            entries_d[tail_q].valid     = 1'b1;
            entries_d[tail_q].done      = 1'b0;
            entries_d[tail_q].reg_write = alloc_reg_write;
            entries_d[tail_q].rd        = alloc_rd;
            entries_d[tail_q].prd       = alloc_prd;
            entries_d[tail_q].old_prd   = alloc_old_prd;
        end
        if (flush_w) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_w) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the entry array is built from flops and fully reset, so valid/done are never X after reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    // Retire strobes last one cycle; data fields hold their last committed value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_valid_q <= 1'b0;
            rob_push_q     <= 1'b0;
            retire_rd_q    <= '0;
            retire_prd_q   <= '0;
            rob_free_reg_q <= '0;
        end else begin
            retire_valid_q <= retire_fire && head_entry.reg_write && !flush_w;
            rob_push_q     <= retire_fire && head_entry.reg_write
                              && (head_entry.old_prd != '0) && !flush_w;
            if (retire_fire && !flush_w) begin
                retire_rd_q    <= head_entry.rd;
                retire_prd_q   <= head_entry.prd;
                rob_free_reg_q <= head_entry.old_prd;
            end
        end
    end

    assign retire_valid = retire_valid_q;
    assign rob_push     = rob_push_q;
    assign retire_rd    = retire_rd_q;
    assign retire_prd   = retire_prd_q;
    assign rob_free_reg = rob_free_reg_q;

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: expected retires are queued at allocation, a monitor pops them on every strobe.
// Define ROB_FLUSH_EN to exercise the flush path as well.
module tb_rob;
    import rob_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     alloc_valid;
    logic                     alloc_reg_write;
    logic [AREG_WIDTH-1:0]    alloc_rd;
    logic [PREG_WIDTH-1:0]    alloc_prd;
    logic [PREG_WIDTH-1:0]    alloc_old_prd;
    logic                     alloc_ready;
    logic [ROB_IDX_WIDTH-1:0] rob_num;
    logic                     cmpl0_valid;
    logic [ROB_IDX_WIDTH-1:0] cmpl0_idx;
    logic                     cmpl1_valid;
    logic [ROB_IDX_WIDTH-1:0] cmpl1_idx;
    logic                     rob_push;
    logic [PREG_WIDTH-1:0]    rob_free_reg;
    logic                     retire_valid;
    logic [AREG_WIDTH-1:0]    retire_rd;
    logic [PREG_WIDTH-1:0]    retire_prd;
    logic [ROB_IDX_WIDTH:0]   count;

    typedef struct {
        logic                  rv;
        logic [AREG_WIDTH-1:0] rd;
        logic [PREG_WIDTH-1:0] prd;
        logic                  push;
        logic [PREG_WIDTH-1:0] free;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    rob dut (
        .clk             (clk),
        .rst             (rst),
`ifdef ROB_FLUSH_EN
        .flush           (flush),
`endif
        .alloc_valid     (alloc_valid),
        .alloc_reg_write (alloc_reg_write),
        .alloc_rd        (alloc_rd),
        .alloc_prd       (alloc_prd),
        .alloc_old_prd   (alloc_old_prd),
        .alloc_ready     (alloc_ready),
        .rob_num         (rob_num),
        .cmpl0_valid     (cmpl0_valid),
        .cmpl0_idx       (cmpl0_idx),
        .cmpl1_valid     (cmpl1_valid),
        .cmpl1_idx       (cmpl1_idx),
        .rob_push        (rob_push),
        .rob_free_reg    (rob_free_reg),
        .retire_valid    (retire_valid),
        .retire_rd       (retire_rd),
        .retire_prd      (retire_prd),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one allocation cycle; `track` queues the expected retire strobe if one will be visible.
    task automatic alloc(input logic rw, input logic [AREG_WIDTH-1:0] rd,
                         input logic [PREG_WIDTH-1:0] prd, input logic [PREG_WIDTH-1:0] old,
                         input logic [ROB_IDX_WIDTH-1:0] exp_tag, input bit track);
        exp_t e;
        alloc_valid     = 1'b1;
        alloc_reg_write = rw;
        alloc_rd        = rd;
        alloc_prd       = prd;
        alloc_old_prd   = old;
        check("alloc_rob_num", rob_num, exp_tag);
        check("alloc_ready", alloc_ready, 1);
        if (track && rw) begin
            e.rv   = 1'b1;
            e.rd   = rd;
            e.prd  = prd;
            e.push = (old != 0);
            e.free = old;
            sb.push_back(e);
        end
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic complete(input logic v0, input logic [ROB_IDX_WIDTH-1:0] i0,
                            input logic v1, input logic [ROB_IDX_WIDTH-1:0] i1);
        cmpl0_valid = v0;
        cmpl0_idx   = i0;
        cmpl1_valid = v1;
        cmpl1_idx   = i1;
        tick();
        cmpl0_valid = 1'b0;
        cmpl1_valid = 1'b0;
    endtask

    // Monitor: every retire strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (retire_valid || rob_push) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", {30'b0, retire_valid, rob_push}, 0);
            end else begin
                mon_e = sb.pop_front();
                check("mon_retire_valid", retire_valid, mon_e.rv);
                check("mon_retire_rd", retire_rd, mon_e.rd);
                check("mon_retire_prd", retire_prd, mon_e.prd);
                check("mon_rob_push", rob_push, mon_e.push);
                check("mon_rob_free_reg", rob_free_reg, mon_e.free);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        flush = 1'b0;
        alloc_valid = 1'b0;
        alloc_reg_write = 1'b0;
        alloc_rd = '0;
        alloc_prd = '0;
        alloc_old_prd = '0;
        cmpl0_valid = 1'b0;
        cmpl0_idx = '0;
        cmpl1_valid = 1'b0;
        cmpl1_idx = '0;
        #12;
        tick();
        rst = 1'b1;
        check("rst_count", count, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_rob_push", rob_push, 0);
        check("rst_retire_valid", retire_valid, 0);
        check("rst_free_reg", rob_free_reg, 0);
        check("rst_retire_rd", retire_rd, 0);
        check("rst_retire_prd", retire_prd, 0);
        check("rst_rob_num", rob_num, 0);

        // Single instruction: completion in N, retire visible in N+2 only.
        alloc(1'b1, 5'd3, 6'd33, 6'd3, 6'd0, 1'b1);
        check("single_count", count, 1);
        complete(1'b1, 6'd0, 1'b0, 6'd0);
        check("single_n1_retire_valid", retire_valid, 0);
        tick();
        check("single_n2_retire_valid", retire_valid, 1);
        check("single_n2_rob_push", rob_push, 1);
        check("single_n2_count", count, 0);
        tick();
        check("single_n3_retire_valid", retire_valid, 0);
        check("single_n3_rob_push", rob_push, 0);
        check("single_n3_rd_hold", retire_rd, 3);

        // Out-of-order completion; tag 3 completed by both ports at once.
        alloc(1'b1, 5'd10, 6'd20, 6'd11, 6'd1, 1'b1);
        alloc(1'b1, 5'd11, 6'd21, 6'd12, 6'd2, 1'b1);
        alloc(1'b1, 5'd12, 6'd22, 6'd13, 6'd3, 1'b1);
        complete(1'b1, 6'd3, 1'b1, 6'd3);
        complete(1'b0, 6'd0, 1'b1, 6'd2);
        check("ooo_hold_count", count, 3);
        complete(1'b1, 6'd1, 1'b0, 6'd0);
        check("ooo_n1_count", count, 3);
        tick();
        check("ooo_n2_count", count, 2);
        check("ooo_n2_rd", retire_rd, 10);
        tick();
        check("ooo_n3_count", count, 1);
        check("ooo_n3_rd", retire_rd, 11);
        tick();
        check("ooo_n4_count", count, 0);
        check("ooo_n4_rd", retire_rd, 12);
        check("ooo_n4_retire_valid", retire_valid, 1);
        tick();

        // Completion to an unallocated tag is ignored; no-write and old_prd=0 retires.
        complete(1'b1, 6'd6, 1'b0, 6'd0);
        alloc(1'b0, 5'd7, 6'd40, 6'd9, 6'd4, 1'b1);
        alloc(1'b1, 5'd8, 6'd41, 6'd0, 6'd5, 1'b1);
        alloc(1'b1, 5'd9, 6'd42, 6'd44, 6'd6, 1'b1);
        complete(1'b1, 6'd4, 1'b1, 6'd5);
        tick();
        check("nowrite_retire_valid", retire_valid, 0);
        check("nowrite_rob_push", rob_push, 0);
        check("nowrite_count", count, 2);
        tick();
        check("oldzero_retire_valid", retire_valid, 1);
        check("oldzero_rob_push", rob_push, 0);
        check("oldzero_free_reg", rob_free_reg, 0);
        check("oldzero_count", count, 1);
        tick();
        tick();
        check("stale_cmpl_count", count, 1);
        check("stale_cmpl_retire_valid", retire_valid, 0);
        complete(1'b1, 6'd6, 1'b0, 6'd0);
        tick();
        check("tag6_rob_push", rob_push, 1);
        check("tag6_count", count, 0);
        tick();

        // Reset mid-run with a retire about to fire: everything discarded, no push.
        for (int i = 0; i < 5; i++) begin
            alloc(1'b1, 5'(i + 1), 6'(i + 50), 6'(i + 30), 6'(7 + i), 1'b0);
        end
        check("pre_rst_count", count, 5);
        complete(1'b1, 6'd7, 1'b0, 6'd0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_count", count, 0);
        check("midrst_alloc_ready", alloc_ready, 1);
        check("midrst_rob_push", rob_push, 0);
        check("midrst_rob_num", rob_num, 0);
        tick();
        check("midrst_edge_rob_push", rob_push, 0);
        tick();
        rst = 1'b1;
        tick();
        check("postrst_rob_push", rob_push, 0);
        check("postrst_retire_valid", retire_valid, 0);
        check("postrst_count", count, 0);
        check("postrst_alloc_ready", alloc_ready, 1);

        // Fill to full, reject the 65th, retire one, allocate into the wrapped slot.
        for (int i = 0; i < 64; i++) begin
            alloc(1'b1, 5'(i), 6'(i), 6'(i + 1), 6'(i), 1'b1);
        end
        check("full_count", count, 64);
        check("full_alloc_ready", alloc_ready, 0);
        alloc_valid = 1'b1;
        alloc_reg_write = 1'b1;
        check("full_rob_num", rob_num, 0);
        tick();
        alloc_valid = 1'b0;
        check("full_ignored_count", count, 64);
        complete(1'b1, 6'd0, 1'b0, 6'd0);
        check("full_retire_cycle_ready", alloc_ready, 0);
        tick();
        check("after_retire_count", count, 63);
        alloc(1'b1, 5'd20, 6'd50, 6'd51, 6'd0, 1'b1);
        check("wrap_count", count, 64);
        for (int i = 1; i < 64; i += 2) begin
            complete(1'b1, 6'(i), 1'b1, 6'(i + 1));
        end
        n = 0;
        while (count != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_count", count, 0);
        tick();
        tick();

`ifdef ROB_FLUSH_EN
        // Flush with a retire pending and a same-cycle allocation.
        for (int i = 0; i < 10; i++) begin
            alloc(1'b1, 5'(i + 2), 6'(i + 10), 6'(i + 40), 6'(1 + i), 1'b0);
        end
        check("preflush_count", count, 10);
        complete(1'b1, 6'd1, 1'b0, 6'd0);
        alloc_valid = 1'b1;
        alloc_reg_write = 1'b1;
        alloc_old_prd = 6'd5;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_rob_num", rob_num, 0);
        check("flush_rob_push", rob_push, 0);
        check("flush_retire_valid", retire_valid, 0);
        tick();
        check("postflush_rob_push", rob_push, 0);
        check("postflush_count", count, 0);
        alloc(1'b1, 5'd1, 6'd2, 6'd3, 6'd0, 1'b1);
        complete(1'b1, 6'd0, 1'b0, 6'd0);
        tick();
        check("postflush_retire_valid", retire_valid, 1);
        tick();
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer: the in-order retirement end of the rename/free-pool loop.
- Dispatch allocates one entry per instruction and receives an in-order tag (`rob_num`).
- The two ALUs report completion by tag.
- The ROB retires the oldest completed entry each cycle. It pushes the displaced physical register back to the free pool and presents the architectural commit (rd to prd) to the register file.

Parameters:
- DEPTH, 64, number of entries; must be a power of 2.
- IDX_WIDTH, 6, log2(DEPTH); width of `rob_num`.
- PREG_WIDTH, 6, physical register tag width.
- AREG_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_reg_write  in  1  the instruction writes a destination register.
- alloc_rd  in  AREG_WIDTH  architectural destination.
- alloc_prd  in  PREG_WIDTH  newly renamed physical destination.
- alloc_old_prd  in  PREG_WIDTH  previous mapping of alloc_rd.
- alloc_ready  out  1  entry available (not full).
- rob_num  out  IDX_WIDTH  tag given to this cycle's allocation; equals tail.
- cmpl0_valid  in  1  ALU0 completion.
- cmpl0_idx  in  IDX_WIDTH  ALU0 completing tag.
- cmpl1_valid  in  1  ALU1 completion.
- cmpl1_idx  in  IDX_WIDTH  ALU1 completing tag.
- rob_push  out  1  push to free pool.
- rob_free_reg  out  PREG_WIDTH  register returned to the free pool.
- retire_valid  out  1  commit strobe to the architectural file.
- retire_rd  out  AREG_WIDTH  committed architectural register.
- retire_prd  out  PREG_WIDTH  committed physical register.
- count  out  IDX_WIDTH+1  occupied entries.

Behaviour:
- **State**
  - Circular array of entries {valid, done, reg_write, rd, prd, old_prd}.
  - head, tail and count registers; pointers wrap modulo DEPTH.
- **Reset** (rst=0, asynchronous)
  - head=tail=count=0; all valid/done bits cleared.
  - rob_push, retire_valid, rob_free_reg, retire_rd, retire_prd all 0.
  - alloc_ready=1 after release.
- **Allocate**
  - Fires when alloc_valid && alloc_ready.
  - Entry[tail] is written with valid=1, done=0; tail advances at the edge.
  - rob_num is combinational from tail, so it is valid in the same cycle.
  - alloc_ready = (count != DEPTH). It does not account for a same-cycle retire (conservative).
- **Complete**
  - For each port, if cmplN_valid and entry[idx].valid, then done<=1 at the edge.
  - A completion to an invalid entry is ignored.
  - Both ports naming the same idx is legal.
- **Retire decision** (combinational on registered state)
  - Fires when entry[head].valid && entry[head].done.
  - On the edge: entry[head].valid<=0, head advances.
  - retire_valid<=entry.reg_write; retire_rd/retire_prd<=entry fields.
  - rob_push<=reg_write && (old_prd != 0); rob_free_reg<=old_prd.
  - At most one retire per cycle, in strict program order.
- **Latency**
  - Completion pulse in cycle N sets done at N+1.
  - Retire outputs are registered and visible in cycle N+2, for one cycle only.
- **Output defaults**
  - With no retire, rob_push and retire_valid are 0 next cycle.
  - Data outputs hold their last value.
- **Simultaneous events**
  - Alloc and retire in the same cycle: count unchanged; both pointers move.
  - Completion of an entry being allocated the same cycle is impossible; the tag is not yet issued.
  - Completion of the head entry while head is not done: it retires the following cycle.
- **Boundaries**
  - Full: count=DEPTH, alloc_ready=0; alloc_valid is ignored.
  - Empty: no retire.
  - Wrap: tail 63 -> 0 and head 63 -> 0 with no bubble.
  - Reset asserted mid-operation discards all entries immediately; no pushes are emitted.

Optional Feature:
- Macro: ROB_FLUSH_EN.
- With the macro: adds input `flush` (1 bit). When flush=1 at an edge:
  - head=tail=count=0 and all valid/done bits are cleared.
  - rob_push and retire_valid are forced 0 that edge.
  - Allocation and completion in the same cycle are discarded.
  - Flush has priority over all other events.
- Without the macro: the port is absent and there is no flush path.

Decomposition:
- Package rob_pkg holds:
  - constants ROB_DEPTH, ROB_IDX_WIDTH, PREG_WIDTH, AREG_WIDTH;
  - the rob_entry_t packed struct {valid, done, reg_write, rd, prd, old_prd}.
- Sub-module rob_ptr: wrap-around pointer with enable, async active-low reset. Instantiated for head and tail.

Test Plan:
- **Reset:** rst=0 mid-run with count=5 -> count=0, alloc_ready=1, rob_push=0 immediately and after release.
- **Single instruction:** alloc rd=3, prd=33, old_prd=3 -> rob_num=0; cmpl0 idx=0 in cycle N -> cycle N+2 retire_valid=1, retire_rd=3, retire_prd=33, rob_push=1, rob_free_reg=3.
- **Out-of-order completion:** alloc tags 0, 1, 2; complete 2, then 1, then 0 -> retires occur as 0, 1, 2 on consecutive cycles after tag 0 completes.
- **Full and wrap:** allocate 64 -> alloc_ready=0 and the 65th alloc is ignored; retire one, alloc one -> rob_num=0 (wrapped), count=64.
- **No push:** alloc with reg_write=0, or old_prd=0 -> retires with rob_push=0. retire_valid=0 for the no-write case and 1 for the old_prd=0 case.
- **Flush (ROB_FLUSH_EN):** 10 entries and simultaneous alloc+flush -> count=0, next rob_num=0, no push is emitted.
